// File: rtl/demux_1xn_router_pkg.sv
// Shared constants and types for the 1-to-N demultiplexer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Holds the default geometry, the accepted-word counter width and the
// per-slot state encoding used by the slot buffer.
package demux_1xn_router_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NOUT  = 4;
    localparam int DEF_SELW  = 2;
    localparam int CNT_W     = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_1xn_router_if.sv
// Stream bundle between one producer, the demux, and NOUT consumers.
// Latency: n/a (wiring only).
// Backpressure: in_ready toward the producer, out_ready per consumer channel.
//
// slave  : the demux side (takes in_*, drives out_* and in_ready)
// master : the producer/consumer side (drives in_* and out_ready)
interface demux_1xn_router_if
    import demux_1xn_router_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NOUT  = DEF_NOUT,
    parameter int SELW  = DEF_SELW
);
    logic [WIDTH-1:0]      in_data;
    logic [SELW-1:0]       in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [NOUT*WIDTH-1:0] out_data;
    logic [NOUT-1:0]       out_valid;
    logic [NOUT-1:0]       out_ready;

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux_1xn_router_slot.sv
// One-entry holding buffer for a single output channel.
// Latency: 1 cycle from load to out_vld.
// Backpressure: holds its word while out_vld & !drain_rdy; reload allowed in the drain cycle.
//
// Ports: clk, rst_n, load (write enable), load_dat (word to store),
//        drain_rdy (consumer ready), out_dat / out_vld (held word and its valid).
module demux_1xn_router_slot
    import demux_1xn_router_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             drain_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             out_vld
);

    slot_state_e state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A load always leaves the slot full, whether or not the old word drains.
    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_EMPTY: if (load)               state_nxt = SLOT_FULL;
            SLOT_FULL:  if (drain_rdy && !load) state_nxt = SLOT_EMPTY;
            default:                            state_nxt = SLOT_EMPTY;
        endcase
    end

    // Data is only written on load, so it stays put across stalls and
    // keeps its last value once the slot empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dat <= '0;
        end else if (load) begin
            out_dat <= load_dat;
        end
    end

    assign out_vld = (state == SLOT_FULL);

endmodule

// File: rtl/demux_1xn_router.sv
// Registered 1-to-N demux: steers each input word into the holding slot named by in_sel.
// Latency: 1 cycle from accept to out_valid/out_data.
// Backpressure: in_ready drops only when the addressed slot is full and not draining; bad selects are always taken and dropped.
//
// Ports: clk, rst_n; bus (slave modport: in_* stream and NOUT out_* channels);
//        sel_err (sticky, a word addressed a channel >= NOUT);
//        acc_cnt (wrapping count of words stored into slots).
module demux_1xn_router
    import demux_1xn_router_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NOUT  = DEF_NOUT,
    parameter int SELW  = DEF_SELW
) (
    input  logic             clk,
    input  logic             rst_n,
    demux_1xn_router_if.slave bus,
    output logic             sel_err,
    output logic [CNT_W-1:0] acc_cnt
);

    localparam int SEL_SPAN = 1 << SELW;

    logic                 sel_ok;
    logic                 accept;
    logic [NOUT-1:0]      load;
    logic [NOUT-1:0]      slot_vld;
    logic [WIDTH-1:0]     slot_dat [NOUT];
    logic [SEL_SPAN-1:0]  slot_open;

    assign sel_ok = (32'(bus.in_sel) < NOUT);

    // One "can take a word" bit per select code. Codes with no channel
    // stay 1 so out-of-range words are swallowed instead of stalling.
    always_comb begin
        slot_open = '1;
        for (int k = 0; k < NOUT; k++) begin
            slot_open[k] = !slot_vld[k] || bus.out_ready[k];
        end
    end

    assign bus.in_ready = slot_open[bus.in_sel];
    assign accept       = bus.in_valid && bus.in_ready;

    for (genvar k = 0; k < NOUT; k++) begin : g_slot
        assign load[k] = accept && sel_ok && (bus.in_sel == SELW'(k));

        demux_1xn_router_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_dat  (bus.in_data),
            .drain_rdy (bus.out_ready[k]),
            .out_dat   (slot_dat[k]),
            .out_vld   (slot_vld[k])
        );
    end

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < NOUT; k++) begin
            bus.out_data[k*WIDTH +: WIDTH] = slot_dat[k];
        end
    end

    assign bus.out_valid = slot_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
            acc_cnt <= '0;
        end else if (accept) begin
            if (sel_ok) begin
                acc_cnt <= acc_cnt + 1'b1;
            end else begin
                sel_err <= 1'b1;
            end
        end
    end

endmodule
